// File: rtl/rs_pkg.sv
// Shared defaults and width helper for the RS decoder correction stage.
package rs_pkg;

    localparam int unsigned RS_N = 255;
    localparam int unsigned RS_K = 239;
    localparam int unsigned RS_T = 8;
    localparam int unsigned RS_M = 8;

    // Bits needed to index v distinct values; never returns less than 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rs_error_correct_stream_if.sv
// Received-data, correction, output and frame-status streams of the correction stage.
interface rs_error_correct_stream_if
    import rs_pkg::*;
#(
    parameter int unsigned M = RS_M,
    parameter int unsigned N = RS_N
);
    localparam int unsigned CNT_W = clog2(N + 1);

    logic [M-1:0]     data_in;
    logic             data_valid;
    logic             data_ready;
    logic             corr_valid;
    logic             corr_ready;
    logic             corr_flag;
    logic [M-1:0]     corr_value;
    logic             corr_fail;
    logic [M-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eof;
    logic             stat_valid;
    logic [CNT_W-1:0] stat_err_cnt;
    logic             stat_uncorr;

    modport master (
        output data_in, data_valid, corr_valid, corr_flag, corr_value, corr_fail, out_ready,
        input  data_ready, corr_ready, out_data, out_valid, out_sof, out_eof,
               stat_valid, stat_err_cnt, stat_uncorr
    );

    modport slave (
        input  data_in, data_valid, corr_valid, corr_flag, corr_value, corr_fail, out_ready,
        output data_ready, corr_ready, out_data, out_valid, out_sof, out_eof,
               stat_valid, stat_err_cnt, stat_uncorr
    );

endinterface

// File: rtl/rs_sym_fifo.sv
// Synchronous first-word-fall-through symbol FIFO; a write while full is dropped.
module rs_sym_fifo
    import rs_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer bit separates full from empty when the indices match
    assign o_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/rs_error_correct_stream.sv
// RS decoder final stage: joins buffered received symbols with Chien/Forney corrections,
// emits corrected symbols with frame markers and a per-frame status report.
module rs_error_correct_stream
    import rs_pkg::*;
#(
    parameter int unsigned N            = RS_N,
    parameter int unsigned K            = RS_K,
    parameter int unsigned T            = RS_T,
    parameter int unsigned M            = RS_M,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned STRIP_PARITY = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    rs_error_correct_stream_if.slave  bus
);
    localparam int unsigned IDX_W    = clog2(N);
    localparam int unsigned CNT_W    = clog2(N + 1);
    localparam bit          STRIP_ON = (STRIP_PARITY != 0);

    logic             w_full;
    logic             w_empty;
    logic [M-1:0]     w_head;
    logic             w_first;
    logic             w_last;
    logic             w_stripped;
    logic             w_eof_pos;
    logic             w_slot_free;
    logic             w_can_fire;
    logic             w_fire;
    logic             w_failed;
    logic [M-1:0]     w_sym;
    logic [CNT_W-1:0] w_cnt_next;

    logic [IDX_W-1:0] r_sym_idx;
    logic             r_fail_lat;
    logic [CNT_W-1:0] r_err_acc;
    logic             r_out_valid;
    logic [M-1:0]     r_out_data;
    logic             r_out_sof;
    logic             r_out_eof;
    logic             r_stat_valid;
    logic [CNT_W-1:0] r_stat_err_cnt;
    logic             r_stat_uncorr;

    rs_sym_fifo #(
        .WIDTH (M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clk_in),
        .i_rst     (rst_in),
        .i_wr_en   (bus.data_valid),
        .i_wr_data (bus.data_in),
        .o_full    (w_full),
        .i_rd_en   (w_fire),
        .o_rd_data (w_head),
        .o_empty   (w_empty)
    );

    // Stripped parity positions are consumed without needing the output register
    assign w_first     = r_sym_idx == '0;
    assign w_last      = 32'(r_sym_idx) == N - 1;
    assign w_stripped  = STRIP_ON && (32'(r_sym_idx) >= K);
    assign w_eof_pos   = STRIP_ON ? (32'(r_sym_idx) == K - 1) : w_last;
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_can_fire  = !w_empty && (w_slot_free || w_stripped);
    assign w_fire      = w_can_fire && bus.corr_valid;

    // The fail flag travels with symbol 0, so that cycle uses it directly
    assign w_failed    = w_first ? bus.corr_fail : r_fail_lat;
    assign w_sym       = (bus.corr_flag && !w_failed) ? (w_head ^ bus.corr_value) : w_head;
    assign w_cnt_next  = (bus.corr_flag && (32'(r_err_acc) < N)) ? r_err_acc + CNT_W'(1) : r_err_acc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sym_idx  <= '0;
            r_fail_lat <= 1'b0;
            r_err_acc  <= '0;
        end else if (w_fire) begin
            r_sym_idx <= w_last ? '0 : r_sym_idx + IDX_W'(1);
            if (w_first) r_fail_lat <= bus.corr_fail;
            r_err_acc <= w_last ? '0 : w_cnt_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_sof      <= 1'b0;
            r_out_eof      <= 1'b0;
            r_stat_valid   <= 1'b0;
            r_stat_err_cnt <= '0;
            r_stat_uncorr  <= 1'b0;
        end else begin
            if (w_fire && !w_stripped) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sym;
                r_out_sof   <= w_first;
                r_out_eof   <= w_eof_pos;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_stat_valid <= w_fire && w_last;
            if (w_fire && w_last) begin
                r_stat_err_cnt <= w_cnt_next;
                r_stat_uncorr  <= w_failed || (32'(w_cnt_next) > T);
            end
        end
    end

    assign bus.data_ready   = !w_full;
    assign bus.corr_ready   = w_can_fire;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_sof      = r_out_sof;
    assign bus.out_eof      = r_out_eof;
    assign bus.stat_valid   = r_stat_valid;
    assign bus.stat_err_cnt = r_stat_err_cnt;
    assign bus.stat_uncorr  = r_stat_uncorr;

endmodule

// File: tb/tb_rs_error_correct_stream.sv
// Scoreboard bench: a default-size decoder and a small stripping decoder driven side by side.
module tb_rs_error_correct_stream;

    typedef struct packed { logic [7:0] data; logic sof; logic eof; } exp_t;
    typedef struct packed { logic flag; logic [7:0] value; logic fail; } corr_t;
    typedef struct packed { int cnt; logic unc; } stat_t;

    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    rs_error_correct_stream_if #(.M(8), .N(255)) bus_a ();
    rs_error_correct_stream_if #(.M(4), .N(15))  bus_b ();

    rs_error_correct_stream #(
        .N(255), .K(239), .T(8), .M(8), .DEPTH(512), .STRIP_PARITY(0)
    ) u_dut_a (
        .clk_in (clk),
        .rst_in (rst_a),
        .bus    (bus_a)
    );

    rs_error_correct_stream #(
        .N(15), .K(11), .T(2), .M(4), .DEPTH(16), .STRIP_PARITY(1)
    ) u_dut_b (
        .clk_in (clk),
        .rst_in (rst_b),
        .bus    (bus_b)
    );

    int         total = 0;
    int         bad   = 0;
    exp_t       eq [2][$];
    stat_t      sq [2][$];
    logic [7:0] dq [2][$];
    corr_t      cq [2][$];
    bit         flg [256];
    logic [7:0] val [256];
    bit         mon_en [2];
    bit         gap_en = 1'b0;
    bit         bp_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_rst(input int s);
        return (s == 0) ? rst_a : rst_b;
    endfunction
    function automatic bit out_vld(input int s);
        return (s == 0) ? bus_a.out_valid : bus_b.out_valid;
    endfunction
    function automatic bit out_rdy(input int s);
        return (s == 0) ? bus_a.out_ready : bus_b.out_ready;
    endfunction
    function automatic exp_t out_now(input int s);
        exp_t o;
        o.data = (s == 0) ? bus_a.out_data : 8'(bus_b.out_data);
        o.sof  = (s == 0) ? bus_a.out_sof  : bus_b.out_sof;
        o.eof  = (s == 0) ? bus_a.out_eof  : bus_b.out_eof;
        return o;
    endfunction
    function automatic bit stat_v(input int s);
        return (s == 0) ? bus_a.stat_valid : bus_b.stat_valid;
    endfunction
    function automatic stat_t stat_now(input int s);
        stat_t st;
        st.cnt = (s == 0) ? int'(bus_a.stat_err_cnt) : int'(bus_b.stat_err_cnt);
        st.unc = (s == 0) ? bus_a.stat_uncorr : bus_b.stat_uncorr;
        return st;
    endfunction
    function automatic bit data_rdy(input int s);
        return (s == 0) ? bus_a.data_ready : bus_b.data_ready;
    endfunction
    function automatic bit corr_rdy(input int s);
        return (s == 0) ? bus_a.corr_ready : bus_b.corr_ready;
    endfunction

    task automatic drive_data(input int s, input logic [7:0] d, input logic v);
        if (s == 0) begin bus_a.data_in = d;      bus_a.data_valid = v; end
        else        begin bus_b.data_in = d[3:0]; bus_b.data_valid = v; end
    endtask

    task automatic drive_corr(input int s, input corr_t c, input logic v);
        if (s == 0) begin
            bus_a.corr_flag = c.flag; bus_a.corr_value = c.value;
            bus_a.corr_fail = c.fail; bus_a.corr_valid = v;
        end else begin
            bus_b.corr_flag = c.flag; bus_b.corr_value = c.value[3:0];
            bus_b.corr_fail = c.fail; bus_b.corr_valid = v;
        end
    endtask

    // Queue one frame of stimulus plus its expected outputs and status
    task automatic build(input int s, input int n, input int k, input bit strip, input bit fail,
                         input logic [7:0] base, input int ecnt, input bit eunc);
        logic [7:0] mask;
        logic [7:0] d;
        logic [7:0] v;
        exp_t       e;
        corr_t      c;
        stat_t      st;
        mask = (s == 0) ? 8'hFF : 8'h0F;
        for (int i = 0; i < n; i++) begin
            d = (base + 8'(i)) & mask;
            v = val[i] & mask;
            c.flag  = flg[i];
            c.value = v;
            c.fail  = (i == 0) ? fail : 1'b0;
            dq[s].push_back(d);
            cq[s].push_back(c);
            if (!strip || i < k) begin
                e.data = (flg[i] && !fail) ? (d ^ v) : d;
                e.sof  = (i == 0);
                e.eof  = (i == (strip ? k - 1 : n - 1));
                eq[s].push_back(e);
            end
            flg[i] = 1'b0;
            val[i] = 8'h00;
        end
        st.cnt = ecnt;
        st.unc = eunc;
        sq[s].push_back(st);
    endtask

    task automatic feed_data(input int s);
        logic [7:0] d;
        bit         ok;
        int         n;
        while (dq[s].size() > 0) begin
            d = dq[s].pop_front();
            drive_data(s, d, 1'b1);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < LIMIT) begin
                @(negedge clk);
                ok = data_rdy(s);
                @(posedge clk);
                n++;
            end
            #1;
            if (!ok) begin
                chk("data_handshake_timeout", 0, 1);
                dq[s].delete();
            end
        end
        drive_data(s, 8'h00, 1'b0);
    endtask

    task automatic feed_corr(input int s);
        corr_t c;
        bit    ok;
        int    n;
        while (cq[s].size() > 0) begin
            c = cq[s].pop_front();
            if (gap_en) begin
                drive_corr(s, '0, 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            drive_corr(s, c, 1'b1);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < LIMIT) begin
                @(negedge clk);
                ok = corr_rdy(s);
                @(posedge clk);
                n++;
            end
            #1;
            if (!ok) begin
                chk("corr_handshake_timeout", 0, 1);
                cq[s].delete();
            end
        end
        drive_corr(s, '0, 1'b0);
    endtask

    task automatic run(input int s);
        int n;
        fork
            feed_data(s);
            feed_corr(s);
        join
        n = 0;
        while ((eq[s].size() > 0 || sq[s].size() > 0) && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("expected_symbols_left", eq[s].size(), 0);
        chk("expected_stats_left", sq[s].size(), 0);
    endtask

    // Monitor: every visible output (stalled or not) is checked against the queue head
    always @(negedge clk) begin
        exp_t  e;
        exp_t  o;
        stat_t st;
        stat_t sa;
        for (int s = 0; s < 2; s++) begin
            if (!in_rst(s) && mon_en[s] && out_vld(s)) begin
                if (eq[s].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_out", s), 1, 0);
                end else begin
                    e = eq[s][0];
                    o = out_now(s);
                    chk($sformatf("dut%0d_out_data", s), int'(o.data), int'(e.data));
                    chk($sformatf("dut%0d_out_sof", s), int'(o.sof), int'(e.sof));
                    chk($sformatf("dut%0d_out_eof", s), int'(o.eof), int'(e.eof));
                    if (out_rdy(s)) void'(eq[s].pop_front());
                end
            end
            if (!in_rst(s) && stat_v(s)) begin
                if (sq[s].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_stat", s), 1, 0);
                end else begin
                    st = sq[s].pop_front();
                    sa = stat_now(s);
                    chk($sformatf("dut%0d_stat_err_cnt", s), sa.cnt, st.cnt);
                    chk($sformatf("dut%0d_stat_uncorr", s), int'(sa.unc), int'(st.unc));
                end
            end
        end
    end

    // Output-ready pattern for the default decoder: 1,0,0,1 repeating under backpressure
    initial begin
        int cyc;
        cyc = 0;
        bus_a.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus_a.out_ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr;
        mon_en[0] = 1'b1;
        mon_en[1] = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_data(0, 8'h00, 1'b0);
        drive_data(1, 8'h00, 1'b0);
        drive_corr(0, '0, 1'b0);
        drive_corr(1, '0, 1'b0);
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin flg[i] = 1'b0; val[i] = 8'h00; end
        repeat (2) @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            chk("reset_out_valid", int'(out_vld(s)), 0);
            chk("reset_data_ready", int'(data_rdy(s)), 1);
            chk("reset_corr_ready", int'(corr_rdy(s)), 0);
            chk("reset_stat_valid", int'(stat_v(s)), 0);
            chk("reset_out_data", int'(out_now(s).data), 0);
            chk("reset_stat_err_cnt", stat_now(s).cnt, 0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame, three corrected errors, then a failed frame, all back to back
        build(0, 255, 239, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        flg[3]   = 1'b1; val[3]   = 8'h5A;
        flg[100] = 1'b1; val[100] = 8'hFF;
        flg[254] = 1'b1; val[254] = 8'h01;
        build(0, 255, 239, 1'b0, 1'b0, 8'h00, 3, 1'b0);
        flg[7] = 1'b1; val[7] = 8'h33;
        build(0, 255, 239, 1'b0, 1'b1, 8'h80, 1, 1'b1);
        run(0);

        // Nine errors (> T) under output backpressure and gapped corrections
        for (int i = 0; i < 9; i++) begin
            flg[i * 20 + 1] = 1'b1;
            val[i * 20 + 1] = 8'(8'h11 * (i + 1));
        end
        build(0, 255, 239, 1'b0, 1'b0, 8'h40, 9, 1'b1);
        bp_mode = 1'b1;
        gap_en  = 1'b1;
        run(0);
        bp_mode = 1'b0;
        gap_en  = 1'b0;

        // Parity stripping on the small decoder, three frames back to back
        flg[2] = 1'b1; val[2] = 8'h03;
        build(1, 15, 11, 1'b1, 1'b0, 8'h00, 1, 1'b0);
        flg[12] = 1'b1; val[12] = 8'h05;
        build(1, 15, 11, 1'b1, 1'b0, 8'h03, 1, 1'b0);
        flg[0] = 1'b1; val[0] = 8'h01;
        flg[5] = 1'b1; val[5] = 8'h02;
        flg[13] = 1'b1; val[13] = 8'h04;
        build(1, 15, 11, 1'b1, 1'b0, 8'h07, 3, 1'b1);
        run(1);

        // Fill the 16-deep FIFO with no corrections flowing
        mon_en[1] = 1'b0;
        bus_b.out_ready = 1'b0;
        wr = 0;
        for (int c = 0; c < 20; c++) begin
            drive_data(1, 8'(c), 1'b1);
            @(negedge clk);
            if (bus_b.data_ready) wr++;
            @(posedge clk);
            #1;
        end
        drive_data(1, 8'h00, 1'b0);
        chk("fifo_writes_until_full", wr, 16);
        chk("data_ready_when_full", int'(bus_b.data_ready), 0);

        // One symbol fires into a stalled output, then reset lands mid-frame
        drive_corr(1, '0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        drive_corr(1, '0, 1'b0);
        chk("stalled_out_valid", int'(bus_b.out_valid), 1);
        chk("stalled_corr_ready", int'(bus_b.corr_ready), 0);
        chk("data_ready_after_pop", int'(bus_b.data_ready), 1);
        #2;
        rst_b = 1'b1;
        #1;
        chk("midreset_out_valid", int'(bus_b.out_valid), 0);
        chk("midreset_data_ready", int'(bus_b.data_ready), 1);
        chk("midreset_corr_ready", int'(bus_b.corr_ready), 0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        bus_b.out_ready = 1'b1;
        mon_en[1] = 1'b1;
        build(1, 15, 11, 1'b1, 1'b0, 8'h09, 0, 1'b0);
        run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
